// File: rtl/lb_mul_pkg.sv
// Shared widths and FSM encoding for the shift-and-add multiplier and its shifter.
package lb_mul_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SH_W   = 4;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lb_shift_multiplier_shifter.sv
// LBShifter: 16-bit logarithmic left shifter, four binary-weighted mux stages.
module LBShifter
    import lb_mul_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [SH_W-1:0]   i_shamt,
    output logic [DATA_W-1:0] o_data_c
);

    logic [DATA_W-1:0] w_s0;
    logic [DATA_W-1:0] w_s1;
    logic [DATA_W-1:0] w_s2;

    assign w_s0     = i_shamt[0] ? {i_data[DATA_W-2:0], 1'b0}  : i_data;
    assign w_s1     = i_shamt[1] ? {w_s0[DATA_W-3:0], 2'b0}    : w_s0;
    assign w_s2     = i_shamt[2] ? {w_s1[DATA_W-5:0], 4'b0}    : w_s1;
    assign o_data_c = i_shamt[3] ? {w_s2[DATA_W-9:0], 8'b0}    : w_s2;

endmodule

// File: rtl/lb_shift_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier: low 16 product bits plus overflow,
// one multiplier bit per cycle using LBShifter as the partial-product generator.
module lb_shift_multiplier
    import lb_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product,
    output logic              overflow
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] w_b_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_accept;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_pp;
    logic [DATA_W:0]   w_sum;
    logic              w_lost;
    logic              w_bit;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_shamt  = SH_W'(r_cnt - CNT_W'(1));
    assign w_bit    = r_b[w_shamt];
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_pp};
    // Bits of a_r pushed past bit 15 by a shift of k-1 are a_r[15:17-k].
    assign w_lost   = (r_a >> (CNT_W'(DATA_W + 1) - r_cnt)) != '0;

    LBShifter u_shifter (
        .i_data   (r_a),
        .i_shamt  (w_shamt),
        .o_data_c (w_pp)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_bit) begin
                    w_acc_nxt = w_sum[DATA_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[DATA_W] | w_lost;
                end
                if (r_cnt == CNT_W'(DATA_W)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = start ? RUN : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_accept) begin
            w_a_nxt   = a;
            w_b_nxt   = b;
            w_cnt_nxt = CNT_W'(1);
            w_acc_nxt = '0;
            w_ovf_nxt = 1'b0;
        end

        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign product  = r_acc;
    assign overflow = r_ovf;

endmodule
